// File: rtl/lvds_tx_link_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lvds_tx_link_framer
// Description : Transmit-side framer for the LVDS test link. Builds the 10-bit
//               parallel word for the serializer. The far-end aligner needs a
//               burst of training words to find word boundaries. After the
//               receiver reports alignment, payload bytes are taken over a
//               valid/ready handshake and sent with a 2-bit header. Idle words
//               fill every cycle that carries no payload.
// Ports       : sysclk      - clock, serializer parallel-word rate
//               rst         - synchronous active-high reset
//               link_en     - link enable; low forces IDLE
//               align_done  - far-end aligned (already synchronous to sysclk)
//               tx_data     - payload byte
//               tx_valid    - tx_data valid
//               tx_ready    - byte accepted this cycle (combinational)
//               tx_out      - registered 10-bit word to the serializer
//               link_up     - registered, high while sending DATA words
//               word_cnt    - payload words sent, wraps at 16 bits
// Revision    : 1.0 - initial release
// ============================================================================
module lvds_tx_link_framer #(
    parameter logic [9:0] TRAIN_PATTERN = 10'h3E0,
    parameter int         MIN_TRAIN     = 64,
    parameter logic [9:0] IDLE_WORD     = 10'h2BC
) (
    input  logic        sysclk,
    input  logic        rst,
    input  logic        link_en,
    input  logic        align_done,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [9:0]  tx_out,
    output logic        link_up,
    output logic [15:0] word_cnt
);

    // Counter is wide enough to hold MIN_TRAIN itself, where it saturates.
    localparam int                TCNT_W       = $clog2(MIN_TRAIN + 1);
    localparam logic [TCNT_W-1:0] C_TRAIN_MAX  = TCNT_W'(MIN_TRAIN);
    localparam logic [TCNT_W-1:0] C_TRAIN_LAST = TCNT_W'(MIN_TRAIN - 1);
    localparam logic [TCNT_W-1:0] C_TRAIN_ONE  = TCNT_W'(1);
    localparam logic [1:0]        C_HDR_DATA   = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAIN = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic [9:0]          tx_out_q,    tx_out_d;
    logic                link_up_q,   link_up_d;
    logic [15:0]         word_cnt_q,  word_cnt_d;
    logic [TCNT_W-1:0]   train_cnt_q, train_cnt_d;

    logic w_ready;
    logic w_accept;

    // Ready drops in the same cycle align_done falls, so no byte is taken
    // while the link is about to retrain.
    assign w_ready  = (state_q == ST_DATA) && link_en && align_done;
    assign w_accept = w_ready && tx_valid;

    always_comb begin
        state_d     = state_q;
        tx_out_d    = tx_out_q;
        link_up_d   = link_up_q;
        word_cnt_d  = word_cnt_q;
        train_cnt_d = train_cnt_q;

        if (!link_en) begin
            state_d     = ST_IDLE;
            tx_out_d    = '0;
            link_up_d   = 1'b0;
            train_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    tx_out_d    = '0;
                    link_up_d   = 1'b0;
                    train_cnt_d = '0;
                    state_d     = ST_TRAIN;
                end
                ST_TRAIN: begin
                    tx_out_d  = TRAIN_PATTERN;
                    link_up_d = 1'b0;
                    if (train_cnt_q < C_TRAIN_MAX) begin
                        train_cnt_d = train_cnt_q + C_TRAIN_ONE;
                    end
                    // The word emitted in this cycle is pattern number
                    // train_cnt_q+1, so leaving at MIN_TRAIN-1 yields
                    // exactly MIN_TRAIN words when already aligned.
                    if ((train_cnt_q >= C_TRAIN_LAST) && align_done) begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!align_done) begin
                        state_d     = ST_TRAIN;
                        train_cnt_d = '0;
                        link_up_d   = 1'b0;
                        tx_out_d    = TRAIN_PATTERN;
                    end else begin
                        link_up_d = 1'b1;
                        if (w_accept) begin
                            tx_out_d   = {C_HDR_DATA, tx_data};
                            word_cnt_d = word_cnt_q + 16'd1;
                        end else begin
                            tx_out_d = IDLE_WORD;
                        end
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    tx_out_d    = '0;
                    link_up_d   = 1'b0;
                    train_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tx_out_q    <= '0;
            link_up_q   <= 1'b0;
            word_cnt_q  <= '0;
            train_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tx_out_q    <= tx_out_d;
            link_up_q   <= link_up_d;
            word_cnt_q  <= word_cnt_d;
            train_cnt_q <= train_cnt_d;
        end
    end

    assign tx_ready = w_ready;
    assign tx_out   = tx_out_q;
    assign link_up  = link_up_q;
    assign word_cnt = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lvds_tx_link_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lvds_tx_link_framer
// Description : Self-checking bench for lvds_tx_link_framer. A vector table
//               covers reset and IDLE/TRAIN entry, hand-written sequences
//               cover the training length, late alignment, payload latency,
//               retrain and counter wrap, and a random phase is compared each
//               cycle against a behavioural model of the link rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lvds_tx_link_framer;

    localparam int         MIN_TRAIN     = 64;
    localparam logic [9:0] TRAIN_PATTERN = 10'h3E0;
    localparam logic [9:0] IDLE_WORD     = 10'h2BC;
    localparam int         M_IDLE        = 0;
    localparam int         M_TRAIN       = 1;
    localparam int         M_DATA        = 2;
    localparam int         N_VEC         = 9;

    logic        sysclk     = 1'b0;
    logic        rst        = 1'b1;
    logic        link_en    = 1'b0;
    logic        align_done = 1'b0;
    logic        tx_valid   = 1'b0;
    logic [7:0]  tx_data    = 8'h00;
    logic        tx_ready;
    logic [9:0]  tx_out;
    logic        link_up;
    logic [15:0] word_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model: link state, pattern words emitted in the current
    // training run, expected registered outputs and sent-word total.
    int         m_state = M_IDLE;
    int         m_trn   = 0;
    logic [9:0] m_out   = 10'h000;
    logic       m_up    = 1'b0;
    int         m_cnt   = 0;

    typedef struct {
        logic        r;
        logic        le;
        logic        al;
        logic        v;
        logic [7:0]  d;
        logic [9:0]  e_out;
        logic        e_up;
        logic        e_rdy;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vt [N_VEC];

    lvds_tx_link_framer dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .link_en    (link_en),
        .align_done (align_done),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_out     (tx_out),
        .link_up    (link_up),
        .word_cnt   (word_cnt)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic m_ready(input logic le, input logic al);
        return (m_state == M_DATA) && le && al;
    endfunction

    // One clock of the link rules, applied in priority order.
    task automatic model_step(input logic r, input logic le, input logic al,
                              input logic v, input logic [7:0] d);
        if (r) begin
            m_state = M_IDLE; m_trn = 0; m_out = 10'h000; m_up = 1'b0; m_cnt = 0;
        end else if (!le) begin
            m_state = M_IDLE; m_trn = 0; m_out = 10'h000; m_up = 1'b0;
        end else if (m_state == M_IDLE) begin
            m_out = 10'h000; m_up = 1'b0; m_trn = 0; m_state = M_TRAIN;
        end else if (m_state == M_TRAIN) begin
            m_out = TRAIN_PATTERN;
            m_up  = 1'b0;
            m_trn = m_trn + 1;
            if (m_trn >= MIN_TRAIN && al) m_state = M_DATA;
        end else if (!al) begin
            m_state = M_TRAIN; m_trn = 0; m_out = TRAIN_PATTERN; m_up = 1'b0;
        end else begin
            m_up = 1'b1;
            if (v) begin
                m_out = {2'b01, d};
                m_cnt = (m_cnt + 1) % 65536;
            end else begin
                m_out = IDLE_WORD;
            end
        end
    endtask

    task automatic tick(input logic r, input logic le, input logic al,
                        input logic v, input logic [7:0] d, input bit chk);
        rst = r; link_en = le; align_done = al; tx_valid = v; tx_data = d;
        @(posedge sysclk);
        model_step(r, le, al, v, d);
        #1;
        if (chk) begin
            check("tx_out",   16'(tx_out),   16'(m_out));
            check("link_up",  16'(link_up),  16'(m_up));
            check("word_cnt", word_cnt,      16'(m_cnt));
            check("tx_ready", 16'(tx_ready), 16'(m_ready(le, al)));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        bit          seen;
        logic [7:0]  b4 [3];
        logic        r, le, al, v;

        //           r     le    al    v     d      out      up    rdy   cnt
        vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 1'b0, 16'h0000};
        vt[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 10'h000, 1'b0, 1'b0, 16'h0000};
        vt[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h34, 10'h000, 1'b0, 1'b0, 16'h0000};
        vt[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h56, 10'h000, 1'b0, 1'b0, 16'h0000};
        vt[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h78, 10'h000, 1'b0, 1'b0, 16'h0000};
        vt[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h9A, 10'h3E0, 1'b0, 1'b0, 16'h0000};
        vt[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hBC, 10'h000, 1'b0, 1'b0, 16'h0000};
        vt[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hDE, 10'h000, 1'b0, 1'b0, 16'h0000};
        vt[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hF0, 10'h000, 1'b0, 1'b0, 16'h0000};

        for (int i = 0; i < N_VEC; i++) begin
            rst = vt[i].r; link_en = vt[i].le; align_done = vt[i].al;
            tx_valid = vt[i].v; tx_data = vt[i].d;
            @(posedge sysclk);
            #1;
            check($sformatf("vec%0d_tx_out", i),   16'(tx_out),   16'(vt[i].e_out));
            check($sformatf("vec%0d_link_up", i),  16'(link_up),  16'(vt[i].e_up));
            check($sformatf("vec%0d_tx_ready", i), 16'(tx_ready), 16'(vt[i].e_rdy));
            check($sformatf("vec%0d_word_cnt", i), word_cnt,      vt[i].e_cnt);
        end
        model_step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        // Aligned from the start: exactly MIN_TRAIN pattern words, then idle.
        n = 0; seen = 0;
        for (int i = 0; i < 300; i++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1);
            if (tx_out === TRAIN_PATTERN) n++;
            if (link_up === 1'b1) begin seen = 1; break; end
        end
        check("t2_link_up_seen",    16'(seen), 16'd1);
        check("t2_pattern_words",   16'(n),    16'(MIN_TRAIN));
        check("t2_first_data_word", 16'(tx_out), 16'(IDLE_WORD));

        // Late alignment: training continues until the cycle after the rise.
        tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1);
        for (int i = 0; i < 201; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1);
        check("t3_rise_out", 16'(tx_out),  16'(TRAIN_PATTERN));
        check("t3_rise_up",  16'(link_up), 16'd0);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1);
        check("t3_data_out", 16'(tx_out),  16'(IDLE_WORD));
        check("t3_data_up",  16'(link_up), 16'd1);

        // Back-to-back payload, one-cycle latency.
        b4[0] = 8'h5A; b4[1] = 8'hA5; b4[2] = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b1, b4[i], 1);
            check($sformatf("t4_byte%0d", i), 16'(tx_out), 16'({2'b01, b4[i]}));
        end
        check("t4_word_cnt", word_cnt, 16'd3);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1);

        // Alignment loss with a pending byte.
        rst = 1'b0; link_en = 1'b1; align_done = 1'b0; tx_valid = 1'b1; tx_data = 8'h77;
        #1;
        check("t5_ready_low", 16'(tx_ready), 16'd0);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 8'h77, 1);
        check("t5_out",  16'(tx_out),  16'(TRAIN_PATTERN));
        check("t5_up",   16'(link_up), 16'd0);
        check("t5_cnt",  word_cnt,     16'd3);
        n = 1; seen = 0;
        for (int i = 0; i < 300; i++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b1, 8'($urandom), 1);
            if (tx_out === TRAIN_PATTERN) n++;
            if (link_up === 1'b1) begin seen = 1; break; end
        end
        check("t5_relink_seen",       16'(seen),            16'd1);
        check("t5_pattern_words_min", 16'(n >= MIN_TRAIN),  16'd1);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            r  = ($urandom_range(0, 499) == 0);
            le = ($urandom_range(0, 199) != 0);
            al = ($urandom_range(0, 99) != 0);
            v  = 1'($urandom_range(0, 1));
            tick(r, le, al, v, 8'($urandom), 1);
        end

        // Counter wrap, then link disable mid-DATA.
        for (int i = 0; i < 300 && m_state != M_DATA; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1);
        check("t6_reach_data", 16'(m_state == M_DATA), 16'd1);
        for (int i = 0; i < 70000 && m_cnt != 65535; i++) tick(1'b0, 1'b1, 1'b1, 1'b1, 8'($urandom), 0);
        check("t6_preset", word_cnt, 16'hFFFF);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 8'h3C, 1);
        check("t6_wrap_cnt", word_cnt,     16'h0000);
        check("t6_wrap_out", 16'(tx_out), 16'h013C);
        tick(1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1);
        check("t6_off_out", 16'(tx_out),  16'h0000);
        check("t6_off_up",  16'(link_up), 16'd0);
        check("t6_off_cnt", word_cnt,     16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
